// File: rtl/btod_issuer_pkg.sv
// Shared types and defaults for the btod command issuer and its watchdog.
package btod_issuer_package;

    localparam int BTOD_REQ_W           = 8;
    localparam int BTOD_ACK_W           = 8;
    localparam int BTOD_LEN_W           = 5;
    localparam int BTOD_WDOG_W          = 16;
    localparam int BTOD_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        NOTIFY,
        WAIT_NACK
    } btodIssState_t;

    typedef logic [BTOD_REQ_W-1:0] btodReq_t;
    typedef logic [BTOD_ACK_W-1:0] btodAck_t;
    typedef logic [BTOD_LEN_W-1:0] btodLen_t;

endpackage

// File: rtl/btod_issuer_if.sv
// Command, btod request/ack and startDone notify/ack channels between the issuer and its neighbours.
interface btod_issuer_if
    import btod_issuer_package::*;
#(
    parameter int REQ_W = BTOD_REQ_W,
    parameter int ACK_W = BTOD_ACK_W,
    parameter int LEN_W = BTOD_LEN_W
);

    logic             cmd_vld;
    logic             cmd_rdy;
    logic [REQ_W-1:0] cmd_base;
    logic [LEN_W-1:0] cmd_len;
    logic             btod_req;
    logic [REQ_W-1:0] btod_req_data;
    logic             btod_ack;
    logic [ACK_W-1:0] btod_ack_data;
    logic             start_notify;
    logic             start_ack;

    // master is the issuer; slave is the command source plus blockB
    modport master (
        input  cmd_vld, cmd_base, cmd_len, btod_ack, btod_ack_data, start_ack,
        output cmd_rdy, btod_req, btod_req_data, start_notify
    );

    modport slave (
        output cmd_vld, cmd_base, cmd_len, btod_ack, btod_ack_data, start_ack,
        input  cmd_rdy, btod_req, btod_req_data, start_notify
    );

endinterface

// File: rtl/btod_issuer_wdog.sv
// Request watchdog: a cleared/incrementing cycle counter that flags when the next increment reaches TIMEOUT.
module btod_wdog
    import btod_issuer_package::*;
#(
    parameter int TIMEOUT = BTOD_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    logic [BTOD_WDOG_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expired during the cycle whose unanswered increment would make the count equal TIMEOUT
    assign o_expired = (r_count == BTOD_WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/btod_issuer.sv
// Burst command issuer: sequential btod requests with one outstanding, ack-data accumulation and startDone notify.
module btod_issuer
    import btod_issuer_package::*;
#(
    parameter int REQ_W   = BTOD_REQ_W,
    parameter int ACK_W   = BTOD_ACK_W,
    parameter int LEN_W   = BTOD_LEN_W,
    parameter int TIMEOUT = BTOD_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    btod_issuer_if.master          bus,
    output logic [ACK_W+LEN_W-1:0] acc_sum,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_spurious
);

    btodIssState_t r_state;
    btodIssState_t w_nextState;

    logic [REQ_W-1:0]       r_base;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_idx;
    logic                   r_gap;
    logic                   r_rdyEn;
    logic [ACK_W+LEN_W-1:0] r_accSum;
    logic                   r_errTimeout;
    logic                   r_errSpurious;

    logic w_accept;
    logic w_ackTaken;
    logic w_lastAck;
    logic w_expired;
    logic w_timeout;
    logic w_spurious;

    assign w_accept   = bus.cmd_vld && bus.cmd_rdy;
    assign w_ackTaken = bus.btod_req && bus.btod_ack;
    assign w_lastAck  = w_ackTaken && ((r_idx + 1'b1) == r_len);
    assign w_timeout  = bus.btod_req && !bus.btod_ack && w_expired;
    assign w_spurious = bus.btod_ack && !bus.btod_req;

    btod_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (!bus.btod_req || bus.btod_ack),
        .i_inc     (bus.btod_req),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = (bus.cmd_len == '0) ? NOTIFY : REQ;
                end
            end
            REQ: begin
                if (w_timeout) begin
                    w_nextState = IDLE;
                end else if (w_lastAck) begin
                    w_nextState = NOTIFY;
                end
            end
            NOTIFY:    w_nextState = bus.start_ack ? IDLE : WAIT_NACK;
            WAIT_NACK: w_nextState = bus.start_ack ? IDLE : WAIT_NACK;
            default:   w_nextState = IDLE;
        endcase
    end

    // The request is withheld for the single gap cycle that follows every non-final ack
    always_comb begin
        bus.cmd_rdy      = 1'b0;
        bus.btod_req     = 1'b0;
        bus.start_notify = 1'b0;
        case (r_state)
            IDLE:    bus.cmd_rdy      = r_rdyEn;
            REQ:     bus.btod_req     = !r_gap;
            NOTIFY:  bus.start_notify = 1'b1;
            default: ;
        endcase
    end

    assign bus.btod_req_data = r_base + REQ_W'(r_idx);
    assign busy              = (r_state != IDLE);
    assign acc_sum           = r_accSum;
    assign err_timeout       = r_errTimeout;
    assign err_spurious      = r_errSpurious;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdyEn       <= 1'b0;
            r_base        <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_gap         <= 1'b0;
            r_accSum      <= '0;
            r_errTimeout  <= 1'b0;
            r_errSpurious <= 1'b0;
        end else begin
            r_rdyEn <= 1'b1;
            if (w_accept) begin
                r_base       <= bus.cmd_base;
                r_len        <= bus.cmd_len;
                r_idx        <= '0;
                r_gap        <= 1'b0;
                r_accSum     <= '0;
                r_errTimeout <= 1'b0;
            end else if (w_ackTaken) begin
                r_accSum <= r_accSum + {{LEN_W{1'b0}}, bus.btod_ack_data};
                r_idx    <= r_idx + 1'b1;
                r_gap    <= 1'b1;
            end else if (r_gap) begin
                r_gap <= 1'b0;
            end
            if (w_timeout) begin
                r_errTimeout <= 1'b1;
            end
            // A stray ack in the accept cycle still counts against the new burst
            r_errSpurious <= (r_errSpurious && !w_accept) || w_spurious;
        end
    end

endmodule

// File: doc/btod_issuer.md
Name: btod_issuer

Overview:
- Upstream command stage that drives blockB's btod request/acknowledge channel and its startDone notify/acknowledge channel.
- Accepts one burst command (base index, length) on a ready/valid port and issues `length` sequential requests on btod, one outstanding at a time.
- Accumulates the returned acknowledge data, then signals completion on startDone.
- Watchdog aborts a request that blockB never acknowledges.

Parameters:
- REQ_W, 8, width of btod request payload (table index).
- ACK_W, 8, width of btod acknowledge payload.
- LEN_W, 5, width of burst length field.
- TIMEOUT, 255, cycles a request may wait for ack before abort; 1..2^16-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- cmd_vld  input  1  burst command valid.
- cmd_rdy  output  1  burst command ready.
- cmd_base  input  REQ_W  first request payload.
- cmd_len  input  LEN_W  number of requests.
- btod_req  output  1  request to blockB.
- btod_req_data  output  REQ_W  request payload.
- btod_ack  input  1  acknowledge from blockB.
- btod_ack_data  input  ACK_W  acknowledge payload.
- start_notify  output  1  completion notify to blockB, one-cycle pulse.
- start_ack  input  1  notify acknowledge from blockB.
- acc_sum  output  ACK_W+LEN_W  sum of ack payloads for current/last burst.
- busy  output  1  high when not IDLE.
- err_timeout  output  1  sticky watchdog abort flag.
- err_spurious  output  1  sticky unexpected-ack flag.

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous and active-low. All flops reset asynchronously.
- Reset values: all outputs 0, except cmd_rdy, which is 0 during reset and 1 the first cycle after release (state IDLE).
- FSM states:
  - IDLE: cmd_rdy=1. On cmd_vld: latch base/len; clear acc_sum, err_timeout, err_spurious. If len==0 go to NOTIFY, else go to REQ with idx=0.
  - REQ: btod_req=1, btod_req_data=base+idx (mod 2^REQ_W, wraps silently). req and data stay stable until btod_ack is sampled high.
  - On ack: acc_sum += ack_data (zero-extended; cannot overflow), idx++, watchdog cleared. btod_req drops to 0 for exactly one cycle (gap), then re-asserts in REQ if idx<len, else the FSM goes to NOTIFY.
  - REQ watchdog: counter increments each cycle req is high without ack. Reaching TIMEOUT sets err_timeout, drops btod_req and goes to IDLE with no notify; acc_sum keeps the partial sum.
  - Ack arriving in the same cycle the count reaches TIMEOUT is accepted; no timeout.
  - NOTIFY: start_notify=1 for exactly one cycle, then WAIT_NACK.
  - start_ack sampled during the NOTIFY cycle itself counts: the FSM goes directly to IDLE.
  - WAIT_NACK: wait for start_ack (no timeout), then IDLE.
- Latency: cmd accept → btod_req high 1 cycle later. Ack → next req 2 cycles later. Last ack → start_notify 1 cycle later.
- btod_ack high while btod_req is low (gap, IDLE, NOTIFY, WAIT_NACK) is ignored for data and sets err_spurious.
- start_ack outside NOTIFY/WAIT_NACK is ignored.
- cmd_vld outside IDLE: not accepted (cmd_rdy=0); the command must be held by the source.
- Reset mid-burst: btod_req and start_notify fall asynchronously; no completion is issued.
- busy = (state != IDLE).

Decomposition:
- Shared package (btod_issuer_package, imported alongside mixed_package):
  - state enum btodIssState_t {IDLE, REQ, NOTIFY, WAIT_NACK};
  - typedefs btodReq_t[REQ_W], btodAck_t[ACK_W], btodLen_t[LEN_W];
  - constant BTOD_TIMEOUT_DEFAULT.
- One natural sub-module: btod_wdog, a 16-bit load/clear/increment counter with an expired output compared against TIMEOUT.

Test Plan:
- cmd base=0x10 len=3; blockB acks 2 cycles after each req with data 5,6,7 → req data 0x10,0x11,0x12; one-cycle gaps; acc_sum=18; one start_notify; busy low after start_ack.
- base=0xFE len=4 → req data 0xFE,0xFF,0x00,0x01 (wrap); no error flags.
- len=0 → no btod_req; start_notify pulse the cycle after accept; acc_sum=0.
- TIMEOUT=8, second ack withheld → btod_req drops after 8 cycles; err_timeout=1; no start_notify; acc_sum=first ack data. Next cmd accept clears err_timeout.
- Ack during a gap cycle → err_spurious=1; acc_sum unchanged. Ack on exactly the TIMEOUT-th cycle → accepted, err_timeout=0.
- Assert rst_n low mid-REQ → btod_req 0 without waiting for a clock edge; after release, cmd_rdy=1 and acc_sum=0.
- start_ack coincident with start_notify → IDLE next cycle.
